// File: rtl/mont_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier: FSM states,
// addend-select encodings and the iteration-counter width helper.
package mont_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        ITER = 3'd2,
        SUB  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Addend selection, indexed by {a, q} of the current iteration.
    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_M    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_BM   = 2'b11;

    // Counter must hold 0..width-1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mont_addsub.sv
// Combinational add/subtract; the single arithmetic unit of the multiplier.
module mont_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/montgomery_param.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start
// captures all operands, so inputs may change on the next cycle. busy is
// high from PRE through SUB; done pulses for exactly one cycle in DONE and
// result stays valid from then until the next SUB completes. Holding start
// high yields one product every WIDTH+3 cycles.
module montgomery_param
    import mont_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             square,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int AW = WIDTH + 2;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH:0]     bm_q;
    logic [WIDTH:0]     c_q;
    logic [WIDTH-1:0]   result_q;
    logic               done_q;
    logic               busy_q;

    logic               bit_a;
    logic               bit_q;
    logic [1:0]         sel;
    logic [WIDTH:0]     addend;
    logic [AW-1:0]      add_a;
    logic [AW-1:0]      add_b;
    logic               add_sub;
    logic [AW-1:0]      add_sum;
    logic [WIDTH:0]     c_d;
    logic [WIDTH:0]     bm_d;
    logic [WIDTH-1:0]   result_d;
    logic               last_iter;

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Pick the iteration addend from the current A bit and the quotient bit.
    always_comb begin
        bit_a  = a_q[0];
        bit_q  = c_q[0] ^ (bit_a & b_q[0]);
        sel    = {bit_a, bit_q};
        addend = '0;
        case (sel)
            SEL_ZERO: addend = '0;
            SEL_M:    addend = {1'b0, m_q};
            SEL_B:    addend = {1'b0, b_q};
            default:  addend = bm_q;
        endcase
    end

    // Route operands into the shared adder: B+M in PRE, C+addend in ITER, C-M in SUB.
    always_comb begin
        add_a   = {1'b0, c_q};
        add_b   = {1'b0, addend};
        add_sub = 1'b0;
        case (state_q)
            PRE: begin
                add_a = {2'b00, b_q};
                add_b = {2'b00, m_q};
            end
            SUB: begin
                add_b   = {2'b00, m_q};
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    mont_addsub #(.W(AW)) u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (add_sum)
    );

    // Next-state values derived from the adder; C < 2M keeps the top bit free.
    always_comb begin
        c_d      = add_sum[WIDTH+1:1];
        bm_d     = add_sum[WIDTH:0];
        result_d = add_sum[WIDTH+1] ? c_q[WIDTH-1:0] : add_sum[WIDTH-1:0];
    end

    // Control FSM with datapath registers and registered done/busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            bm_q     <= '0;
            c_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= in_a;
                        b_q     <= square ? in_a : in_b;
                        m_q     <= in_m;
                        c_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= PRE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PRE: begin
                    bm_q    <= bm_d;
                    c_q     <= '0;
                    state_q <= ITER;
                end
                ITER: begin
                    c_q   <= c_d;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    result_q <= result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_param.sv
// Bench for montgomery_param: an 8-bit instance with directed vectors and a
// 1024-bit instance with random operands; a monitor per instance pops the
// expected result and done cycle whenever done is seen.
module tb_montgomery_param;

    localparam int SW = 8;
    localparam int BW = 1024;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;

    // small instance
    logic          start = 1'b0;
    logic          square = 1'b0;
    logic [SW-1:0] in_a = '0;
    logic [SW-1:0] in_b = '0;
    logic [SW-1:0] in_m = '0;
    logic [SW-1:0] result;
    logic          done;
    logic          busy;
    logic [2:0]    dbg_state;

    // big instance
    logic          start_b = 1'b0;
    logic          square_b = 1'b0;
    logic [BW-1:0] a_b = '0;
    logic [BW-1:0] b_b = '0;
    logic [BW-1:0] m_b = '0;
    logic [BW-1:0] result_b;
    logic          done_b;
    logic          busy_b;
    logic [2:0]    dbg_state_b;

    int n_checks = 0;
    int n_pass = 0;

    logic [SW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [BW-1:0] exp_big_q[$];
    int            exp_big_cyc_q[$];

    montgomery_param #(.WIDTH(SW)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .square    (square),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_m      (in_m),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    montgomery_param #(.WIDTH(BW)) u_big (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start_b),
        .square    (square_b),
        .in_a      (a_b),
        .in_b      (b_b),
        .in_m      (m_b),
        .result    (result_b),
        .done      (done_b),
        .busy      (busy_b),
        .dbg_state (dbg_state_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (low 128 bits shown)", name, act[127:0], exp[127:0]);
        end
    endtask

    // ---------------- reference model for the big instance ----------------
    // A*B mod M by shift-and-add, then divide by 2^BW with modular halving.
    function automatic logic [BW-1:0] mont_ref(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                               input logic [BW-1:0] m);
        logic [BW+1:0] acc;
        logic [BW+1:0] mm;
        acc = '0;
        mm  = {2'b00, m};
        for (int i = BW - 1; i >= 0; i--) begin
            acc = acc << 1;
            if (acc >= mm) acc = acc - mm;
            if (b[i]) acc = acc + {2'b00, a};
            if (acc >= mm) acc = acc - mm;
        end
        for (int i = 0; i < BW; i++) begin
            if (acc[0]) acc = (acc + mm) >> 1;
            else        acc = acc >> 1;
        end
        return acc[BW-1:0];
    endfunction

    // ---------------- monitors ----------------
    int  busy_run = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            busy_run  = 0;
            done_prev = 1'b0;
        end else begin
            if (busy) busy_run++;
            if (done && done_prev) check("done_single_cycle", 1, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("result", result, exp_q.pop_front());
                    check("done_cycle", cyc, exp_cyc_q.pop_front());
                    check("busy_cycles", busy_run, SW + 2);
                end
                busy_run = 0;
            end
            done_prev = done;
        end
    end

    int busy_run_b = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            busy_run_b = 0;
        end else begin
            if (busy_b) busy_run_b++;
            if (done_b) begin
                if (exp_big_q.size() == 0) begin
                    check("unexpected_done_big", 1, 0);
                end else begin
                    check("result_big", result_b, exp_big_q.pop_front());
                    check("done_cycle_big", cyc, exp_big_cyc_q.pop_front());
                    check("busy_cycles_big", busy_run_b, BW + 2);
                end
                busy_run_b = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after the falling edge, after the monitors sample.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic garbage();
        in_a   = SW'($urandom_range(0, 255));
        in_b   = SW'($urandom_range(0, 255));
        in_m   = SW'($urandom_range(0, 255));
        square = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic [SW-1:0] m,
                         input logic sq, input logic [SW-1:0] exp);
        step();
        in_a = a; in_b = b; in_m = m; square = sq; start = 1'b1;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + SW + 3);
        step();
        start = 1'b0;
        garbage();
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_big_q.size() != 0) && n < limit) begin
            step();
            n++;
        end
        if (exp_q.size() != 0 || exp_big_q.size() != 0) begin
            check("drain_timeout", 1, 0);
            exp_q.delete(); exp_cyc_q.delete();
            exp_big_q.delete(); exp_big_cyc_q.delete();
        end
        repeat (3) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        logic [BW-1:0] ra, rb, rm;

        // reset state
        #3;
        check("reset_result", result, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_state", dbg_state, 0);
        step();
        resetn = 1'b1;
        repeat (2) step();

        // basic product and square with garbage in_b
        issue(8'd5, 8'd7, 8'd13, 1'b0, 8'd1);
        wait_drain(100);
        issue(8'd12, 8'hFF, 8'd13, 1'b1, 8'd3);
        wait_drain(100);

        // final-subtraction boundary and zero operand
        issue(8'd254, 8'd254, 8'd255, 1'b0, 8'd1);
        wait_drain(100);
        issue(8'd0, 8'd200, 8'd255, 1'b0, 8'd0);
        wait_drain(100);

        // start pulse while busy must be ignored
        issue(8'd7, 8'd9, 8'd15, 1'b0, 8'd3);
        repeat (3) step();
        in_a = 8'd1; in_b = 8'd1; in_m = 8'd3; square = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        wait_drain(100);
        repeat (15) step();

        // start held high: three back-to-back products
        step();
        n0 = cyc;
        in_a = 8'd5; in_b = 8'd7; in_m = 8'd13; square = 1'b0; start = 1'b1;
        exp_q.push_back(8'd1);  exp_cyc_q.push_back(n0 + 11);
        exp_q.push_back(8'd4);  exp_cyc_q.push_back(n0 + 22);
        exp_q.push_back(8'd29); exp_cyc_q.push_back(n0 + 33);
        for (int j = 1; j <= 33; j++) begin
            step();
            if (j == 11) begin
                in_a = 8'd3; in_b = 8'd4; in_m = 8'd11; square = 1'b0;
            end else if (j == 22) begin
                in_a = 8'd100; in_b = 8'd50; in_m = 8'd101; square = 1'b0;
            end else if (j == 33) begin
                start = 1'b0;
                garbage();
            end else begin
                garbage();
            end
        end
        wait_drain(100);
        repeat (15) step();

        // asynchronous reset during the 4th ITER cycle
        step();
        n0 = cyc;
        in_a = 8'd5; in_b = 8'd7; in_m = 8'd13; square = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < n0 + 5) step();
        check("mid_iter_state", dbg_state, 2);
        check("mid_iter_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_done", done, 0);
        check("async_reset_result", result, 0);
        check("async_reset_state", dbg_state, 0);
        repeat (2) step();
        resetn = 1'b1;
        step();
        issue(8'd5, 8'd7, 8'd13, 1'b0, 8'd1);
        wait_drain(100);

        // 1024-bit instance with random odd moduli
        for (int v = 0; v < 3; v++) begin
            for (int w = 0; w < BW / 32; w++) begin
                rm[w*32 +: 32] = $urandom;
                ra[w*32 +: 32] = $urandom;
                rb[w*32 +: 32] = $urandom;
            end
            rm[BW-1] = 1'b1; rm[0] = 1'b1;
            ra[BW-1] = 1'b0; rb[BW-1] = 1'b0;
            step();
            a_b = ra; b_b = rb; m_b = rm; start_b = 1'b1;
            exp_big_q.push_back(mont_ref(ra, rb, rm));
            exp_big_cyc_q.push_back(cyc + BW + 3);
            step();
            start_b = 1'b0;
            a_b = '0; b_b = '1; m_b = '0;
            wait_drain(BW + 100);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
